seg7_scan_driver: RTL

Display-side consumer of the syscall output register: accepts a 32-bit value on a load strobe and shows it as 8 hex digits on a time-multiplexed common-anode seven-segment display. New values are held in a pending register and committed only at a frame boundary, so a scan frame never shows digits from two different values. Sits between the pipeline's syscall display latch and the board's AN/SEG pins.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 96 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex glyph table for the seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned GLYPH_W    = 7;
  localparam int unsigned OUT_W      = 8;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g; index 0 is the rightmost entry
  localparam logic [15:0][GLYPH_W-1:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [GLYPH_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high a..g pattern, forced dark when blanked.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0]   nibble,
  input  logic               blank,
  output logic [GLYPH_W-1:0] pattern_c
);

  assign pattern_c = blank ? '0 : hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit hex display driver; new values commit only at frame boundaries
// so a single scan frame never mixes digits from two values.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  an,
  output logic [OUT_W-1:0]  seg,
  output logic              frame_start
);

  localparam int unsigned       CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
  // XOR mask that turns active-high internal values into pin polarity
  localparam logic [OUT_W-1:0]  POL_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CNT_W-1:0]   div_cnt, div_nxt;
  logic [DIGIT_W-1:0] digit, digit_nxt;
  logic [DATA_W-1:0]  disp_val, disp_nxt;
  logic [DATA_W-1:0]  pend_val, pend_val_nxt;
  logic               pend, pend_nxt;
  logic               wrap, boundary;

  logic [DATA_W-1:0]  shifted;
  logic [NIB_W-1:0]   nibble;
  logic               blank;
  logic [GLYPH_W-1:0] pattern_c;
  logic [OUT_W-1:0]   an_sel;

  // Divider, digit counter and pending/commit next-state
  always_comb begin
    wrap         = (div_cnt == CNT_LAST);
    div_nxt      = wrap ? '0 : div_cnt + CNT_W'(1);
    digit_nxt    = wrap ? digit + DIGIT_W'(1) : digit;
    boundary     = wrap && (digit == LAST_DIGIT);
    disp_nxt     = disp_val;
    pend_val_nxt = pend_val;
    pend_nxt     = pend;
    if (boundary) begin
      if (load) begin
        disp_nxt = din;
      end else if (pend) begin
        disp_nxt = pend_val;
      end
      pend_nxt = 1'b0;
    end else if (load) begin
      pend_val_nxt = din;
      pend_nxt     = 1'b1;
    end
  end

  // Outputs are built from next-state so they change on the same edge as digit/disp_val
  always_comb begin
    shifted = disp_nxt >> {digit_nxt, 2'b00};
    nibble  = shifted[NIB_W-1:0];
    blank   = BLANK_LZ && (digit_nxt != '0) && (shifted == '0);
    an_sel  = OUT_W'(1) << digit_nxt;
  end

  seg7_decode u_decode (
    .nibble    (nibble),
    .blank     (blank),
    .pattern_c (pattern_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      digit       <= '0;
      disp_val    <= '0;
      pend_val    <= '0;
      pend        <= 1'b0;
      an          <= POL_MASK;
      seg         <= POL_MASK;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      digit       <= digit_nxt;
      disp_val    <= disp_nxt;
      pend_val    <= pend_val_nxt;
      pend        <= pend_nxt;
      an          <= an_sel ^ POL_MASK;
      seg         <= {1'b0, pattern_c} ^ POL_MASK;
      frame_start <= boundary;
    end
  end

endmodule
